// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
package if_prefetch_queue_pkg;

  localparam int          IF_QENTRY_WIDTH  = 65;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c00_0000;

  typedef struct packed {
    logic        adef;
    logic [31:0] pc;
    logic [31:0] inst;
  } qentry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Bus bundle between redirect logic, instruction SRAM, ID stage and the prefetch queue.
// Handshakes: a request transfers on a cycle where inst_sram_req & inst_sram_addr_ok;
// a response transfers on any cycle with inst_sram_data_ok; an instruction transfers
// to ID on a cycle where id_valid & id_allowin. A valid holds its payload until taken.
interface if_prefetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_stall;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        id_valid;
  logic        id_allowin;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_excp_adef;
  logic [7:0]  dbg_out_cnt;
  logic [7:0]  dbg_disc_cnt;
  logic        dbg_halt;

  modport slave (
    input  redirect_valid, redirect_pc, fetch_stall,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, id_allowin,
    output inst_sram_req, inst_sram_addr, id_valid, id_inst, id_pc, id_excp_adef,
    output dbg_out_cnt, dbg_disc_cnt, dbg_halt
  );

  modport master (
    output redirect_valid, redirect_pc, fetch_stall,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, id_allowin,
    input  inst_sram_req, inst_sram_addr, id_valid, id_inst, id_pc, id_excp_adef,
    input  dbg_out_cnt, dbg_disc_cnt, dbg_halt
  );
endinterface

// File: rtl/if_sync_fifo.sv
// Synchronous FIFO with flush; pointers carry an extra wrap bit to tell full from empty.
module if_sync_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int PD    = 1 << AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_count
);

  logic [W-1:0] r_mem [PD];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign o_count = r_wptr - r_rptr;
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < PD; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_wdata;
        r_wptr                <= r_wptr + (AW+1)'(1);
      end
      if (i_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: up to MAX_OUT SRAM requests in flight, DEPTH-entry queue to ID.
// Define IF_PREFETCH_BYPASS_EN to forward a response straight to ID when the queue is empty.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic           clk,
  input logic           resetn,
  if_prefetch_queue_if.slave bus
);

  localparam int CW  = $clog2(MAX_OUT + 1);
  localparam int QAW = $clog2(DEPTH);
  localparam int TAW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [31:0] r_fetch_pc;
  logic [CW-1:0] r_out_cnt;
  logic [CW-1:0] r_disc_cnt;
  logic        r_halt;

  logic        w_misaligned, w_credit, w_req, w_acc, w_rsp, w_drop, w_rsp_enq;
  logic        w_adef_enq, w_byp_show, w_byp_take, w_q_push, w_q_pop;
  qentry_t     w_q_wdata, w_q_head;
  logic        w_q_empty, w_q_full;
  logic [QAW:0] w_q_count;
  logic [31:0] w_tag_head;
  logic        w_tag_empty, w_tag_full;
  logic [TAW:0] w_tag_count;
  logic        w_unused_tag;

  assign w_misaligned = |r_fetch_pc[1:0];
  // Credit covers both in-flight responses and queued entries, so the queue never overflows.
  assign w_credit     = (32'(r_out_cnt) + 32'(w_q_count)) < 32'(DEPTH);
  assign w_req        = resetn & ~bus.redirect_valid & ~bus.fetch_stall & ~r_halt &
                        ~w_misaligned & (r_out_cnt < CW'(MAX_OUT)) & w_credit;
  assign w_acc        = w_req & bus.inst_sram_addr_ok;
  assign w_rsp        = bus.inst_sram_data_ok;
  assign w_drop       = w_rsp & ((r_disc_cnt != '0) | bus.redirect_valid);
  assign w_rsp_enq    = w_rsp & ~w_drop;
  assign w_adef_enq   = ~bus.redirect_valid & ~r_halt & w_misaligned &
                        (r_out_cnt == '0) & (r_disc_cnt == '0) & ~w_q_full;

`ifdef IF_PREFETCH_BYPASS_EN
  assign w_byp_show = w_q_empty & w_rsp_enq;
`else
  assign w_byp_show = 1'b0;
`endif
  assign w_byp_take = w_byp_show & bus.id_allowin;

  assign w_q_push  = (w_rsp_enq & ~w_byp_take) | w_adef_enq;
  assign w_q_pop   = ~w_q_empty & ~bus.redirect_valid & bus.id_allowin;
  assign w_q_wdata = w_adef_enq ? qentry_t'{adef: 1'b1, pc: r_fetch_pc, inst: 32'd0}
                                : qentry_t'{adef: 1'b0, pc: w_tag_head, inst: bus.inst_sram_rdata};

  if_sync_fifo #(.W(32), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .i_flush (1'b0),
    .i_push  (w_acc),
    .i_wdata (r_fetch_pc),
    .i_pop   (w_rsp),
    .o_rdata (w_tag_head),
    .o_empty (w_tag_empty),
    .o_full  (w_tag_full),
    .o_count (w_tag_count)
  );

  assign w_unused_tag = ^{w_tag_empty, w_tag_full, w_tag_count};

  if_sync_fifo #(.W(IF_QENTRY_WIDTH), .DEPTH(DEPTH)) u_inst_q (
    .clk     (clk),
    .rst_n   (resetn),
    .i_flush (bus.redirect_valid),
    .i_push  (w_q_push),
    .i_wdata (w_q_wdata),
    .i_pop   (w_q_pop),
    .o_rdata (w_q_head),
    .o_empty (w_q_empty),
    .o_full  (w_q_full),
    .o_count (w_q_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fetch_pc <= RESET_PC;
      r_out_cnt  <= '0;
      r_disc_cnt <= '0;
      r_halt     <= 1'b0;
    end else begin
      r_out_cnt <= r_out_cnt + CW'(w_acc) - CW'(w_rsp);
      if (bus.redirect_valid) begin
        r_fetch_pc <= bus.redirect_pc;
        r_halt     <= 1'b0;
        // Every request still in flight after this cycle is stale.
        r_disc_cnt <= r_out_cnt - CW'(w_rsp);
      end else begin
        if (w_acc)      r_fetch_pc <= next_pc(r_fetch_pc);
        if (w_adef_enq) r_halt     <= 1'b1;
        if (w_drop)     r_disc_cnt <= r_disc_cnt - CW'(1);
      end
    end
  end

  assign bus.inst_sram_req  = w_req;
  assign bus.inst_sram_addr = r_fetch_pc;
  assign bus.id_valid       = (~w_q_empty | w_byp_show) & ~bus.redirect_valid;
  assign bus.id_inst        = w_byp_show ? bus.inst_sram_rdata : w_q_head.inst;
  assign bus.id_pc          = w_byp_show ? w_tag_head : w_q_head.pc;
  assign bus.id_excp_adef   = w_byp_show ? 1'b0 : w_q_head.adef;
  assign bus.dbg_out_cnt    = 8'(r_out_cnt);
  assign bus.dbg_disc_cnt   = 8'(r_disc_cnt);
  assign bus.dbg_halt       = r_halt;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with a latency-programmable instruction SRAM model.
module tb_if_prefetch_queue;

  localparam logic [31:0] KEY = 32'h5a5a_a5a5;
`ifdef IF_PREFETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk;
  logic resetn;
  if_prefetch_queue_if bus ();

  if_prefetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h1c00_0000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  logic        got_adef[$];
  logic [31:0] hs_log[$];

  // SRAM model: accepts every request, answers in order after lat cycles
  int          lat = 1;
  int          cyc = 0;
  logic [31:0] pend_a[$];
  int          pend_d[$];
  logic        s_hs, s_dok;
  logic [31:0] s_addr;

  always @(negedge clk) begin
    s_hs   = resetn & bus.inst_sram_req & bus.inst_sram_addr_ok;
    s_addr = bus.inst_sram_addr;
    s_dok  = bus.inst_sram_data_ok;
    if (s_hs) hs_log.push_back(s_addr);
    if (resetn && bus.id_valid && bus.id_allowin) begin
      got_pc.push_back(bus.id_pc);
      got_inst.push_back(bus.id_inst);
      got_adef.push_back(bus.id_excp_adef);
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (resetn) begin
      if (s_dok && pend_a.size() > 0) begin
        void'(pend_a.pop_front());
        void'(pend_d.pop_front());
      end
      if (s_hs) begin
        pend_a.push_back(s_addr);
        pend_d.push_back(cyc + lat - 1);
      end
      if (pend_a.size() > 0 && pend_d[0] <= cyc) begin
        bus.inst_sram_data_ok = 1'b1;
        bus.inst_sram_rdata   = pend_a[0] ^ KEY;
      end else begin
        bus.inst_sram_data_ok = 1'b0;
        bus.inst_sram_rdata   = 32'd0;
      end
    end
  end

  always @(negedge resetn) begin
    pend_a.delete();
    pend_d.delete();
    bus.inst_sram_data_ok = 1'b0;
    bus.inst_sram_rdata   = 32'd0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    got_pc.delete();
    got_inst.delete();
    got_adef.delete();
    hs_log.delete();
  endtask

  task automatic drain(input string tag);
    int n;
    bus.fetch_stall = 1'b1;
    bus.id_allowin  = 1'b1;
    n = 0;
    @(negedge clk);
    while ((bus.dbg_out_cnt != 8'd0 || bus.id_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 32'(n < 60), 32'd1);
    @(posedge clk); #1;
  endtask

  // scoreboard: every accepted address is delivered once, in order, from base upward
  task automatic check_stream(input string tag, input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < hs_log.size(); i++) exp_q.push_back(base + 32'(4 * i));
    chk({tag, "_enough_reqs"}, 32'(hs_log.size() >= 4), 32'd1);
    chk({tag, "_count"}, 32'(got_pc.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_pc.size(); i++) begin
      chk({tag, "_addr"}, hs_log[i], exp_q[i]);
      chk({tag, "_pc"}, got_pc[i], exp_q[i]);
      chk({tag, "_inst"}, got_inst[i], exp_q[i] ^ KEY);
      chk({tag, "_adef"}, 32'(got_adef[i]), 32'd0);
    end
    clear_logs();
  endtask

  initial begin
    int n;
    resetn                = 1'b0;
    bus.redirect_valid    = 1'b0;
    bus.redirect_pc       = 32'd0;
    bus.fetch_stall       = 1'b0;
    bus.id_allowin        = 1'b1;
    bus.inst_sram_addr_ok = 1'b1;
    bus.inst_sram_data_ok = 1'b0;
    bus.inst_sram_rdata   = 32'd0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   32'(bus.inst_sram_req), 32'd0);
    chk("rst_addr",  bus.inst_sram_addr, 32'h1c00_0000);
    chk("rst_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_inst",  bus.id_inst, 32'd0);
    chk("rst_pc",    bus.id_pc, 32'd0);
    chk("rst_adef",  32'(bus.id_excp_adef), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    clear_logs();

    // latency 1 stream, first request straight after reset
    @(negedge clk);
    chk("b_first_req",  32'(bus.inst_sram_req), 32'd1);
    chk("b_first_addr", bus.inst_sram_addr, 32'h1c00_0000);
    @(negedge clk);
    chk("b_valid_c1", 32'(bus.id_valid), 32'(BYP));
    @(negedge clk);
    chk("b_valid_c2", 32'(bus.id_valid), 32'd1);
    chk("b_pc_c2",    bus.id_pc, BYP ? 32'h1c00_0004 : 32'h1c00_0000);
    repeat (8) @(negedge clk);

    // ID back-pressure: credit stops requests once the queue is full
    @(posedge clk); #1;
    bus.id_allowin = 1'b0;
    repeat (10) @(negedge clk);
    chk("bp_req",   32'(bus.inst_sram_req), 32'd0);
    chk("bp_out",   32'(bus.dbg_out_cnt), 32'd0);
    chk("bp_valid", 32'(bus.id_valid), 32'd1);
    @(posedge clk); #1;
    drain("b");
    check_stream("b", 32'h1c00_0000);

    // redirect with two requests in flight
    lat = 4;
    bus.fetch_stall = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.dbg_out_cnt != 8'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("c_inflight_wait", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h1c00_1000;
    clear_logs();
    @(negedge clk);
    chk("c_valid_at_redir", 32'(bus.id_valid), 32'd0);
    chk("c_req_at_redir",   32'(bus.inst_sram_req), 32'd0);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("c_disc", 32'(bus.dbg_disc_cnt), 32'd2);
    chk("c_out",  32'(bus.dbg_out_cnt), 32'd2);
    chk("c_addr", bus.inst_sram_addr, 32'h1c00_1000);
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    drain("c");
    check_stream("c", 32'h1c00_1000);

    // redirect coinciding with data_ok and addr_ok
    lat = 1;
    bus.fetch_stall = 1'b0;
    repeat (6) @(negedge clk);
    chk("d_out_before", 32'(bus.dbg_out_cnt), 32'd1);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h1c00_2000;
    clear_logs();
    @(negedge clk);
    chk("d_valid_at_redir", 32'(bus.id_valid), 32'd0);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("d_disc", 32'(bus.dbg_disc_cnt), 32'd0);
    chk("d_out",  32'(bus.dbg_out_cnt), 32'd0);
    chk("d_req",  32'(bus.inst_sram_req), 32'd1);
    chk("d_addr", bus.inst_sram_addr, 32'h1c00_2000);
    repeat (12) @(negedge clk);
    @(posedge clk); #1;
    drain("d");
    check_stream("d", 32'h1c00_2000);

    // misaligned redirect: one adef entry after drain, then halt
    lat = 3;
    bus.fetch_stall = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h1c00_0002;
    clear_logs();
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("e_disc", 32'(bus.dbg_disc_cnt), 32'd1);
    chk("e_out",  32'(bus.dbg_out_cnt), 32'd1);
    n = 0;
    while (!bus.id_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("e_adef_wait", 32'(n < 20), 32'd1);
    chk("e_adef",      32'(bus.id_excp_adef), 32'd1);
    chk("e_pc",        bus.id_pc, 32'h1c00_0002);
    chk("e_inst",      bus.id_inst, 32'd0);
    repeat (10) @(negedge clk);
    chk("e_req_halted", 32'(bus.inst_sram_req), 32'd0);
    chk("e_valid_idle", 32'(bus.id_valid), 32'd0);
    chk("e_halt",       32'(bus.dbg_halt), 32'd1);
    @(posedge clk); #1;
    chk("e_no_reqs",    32'(hs_log.size()), 32'd0);
    chk("e_one_entry",  32'(got_pc.size()), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h1c00_3000;
    clear_logs();
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("e_resume_req",  32'(bus.inst_sram_req), 32'd1);
    chk("e_resume_addr", bus.inst_sram_addr, 32'h1c00_3000);
    chk("e_halt_clear",  32'(bus.dbg_halt), 32'd0);

    // asynchronous reset in mid-stream
    lat = 1;
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    chk("f_req",   32'(bus.inst_sram_req), 32'd0);
    chk("f_valid", 32'(bus.id_valid), 32'd0);
    chk("f_addr",  bus.inst_sram_addr, 32'h1c00_0000);
    chk("f_out",   32'(bus.dbg_out_cnt), 32'd0);
    chk("f_disc",  32'(bus.dbg_disc_cnt), 32'd0);
    chk("f_pc",    bus.id_pc, 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
